// File: rtl/bmu_pkg.sv
// ============================================================================
// Module  : bmu_pkg
// Purpose : Shared types and constants for the bit-manipulation execute
//           stage: op-code enumeration, data width, and the stage-1
//           payload record.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package bmu_pkg;

  localparam int BMU_XLEN = 32;

  // Upper bound for the destination tag carried in the stage-1 record; the
  // execute stage zero-extends its TAG_W-bit tag into this field.
  localparam int BMU_TAG_MAX_W = 16;

  // Codes 20..31 are undefined and flagged as illegal by the execute stage.
  typedef enum logic [4:0] {
    BMU_SH1ADD = 5'd0,
    BMU_SH2ADD = 5'd1,
    BMU_SH3ADD = 5'd2,
    BMU_ANDN   = 5'd3,
    BMU_ORN    = 5'd4,
    BMU_XNOR   = 5'd5,
    BMU_CLZ    = 5'd6,
    BMU_CTZ    = 5'd7,
    BMU_CPOP   = 5'd8,
    BMU_MIN    = 5'd9,
    BMU_MAX    = 5'd10,
    BMU_MINU   = 5'd11,
    BMU_MAXU   = 5'd12,
    BMU_SEXTB  = 5'd13,
    BMU_SEXTH  = 5'd14,
    BMU_ZEXTH  = 5'd15,
    BMU_ROL    = 5'd16,
    BMU_ROR    = 5'd17,
    BMU_ORCB   = 5'd18,
    BMU_REV8   = 5'd19
  } bmu_op_e;

  // The op is kept as raw bits so an out-of-range code survives into the
  // result decode, where it is reported as illegal.
  typedef struct packed {
    logic [4:0]               op;
    logic [BMU_XLEN-1:0]      rs1;
    logic [BMU_XLEN-1:0]      rs2;
    logic [BMU_TAG_MAX_W-1:0] tag;
  } bmu_s1_t;

endpackage

`default_nettype wire

// File: rtl/zba_zbb.sv
// ============================================================================
// Module  : zba_zbb
// Purpose : Combinational Zba/Zbb unit. Computes every supported result in
//           parallel from the two operands; the caller selects one.
// Ports   : in1_i, in2_i      operands (32 bits each)
//           <op>_o            one 32-bit result per supported operation
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module zba_zbb
  import bmu_pkg::*;
(
  input  logic [BMU_XLEN-1:0] in1_i,
  input  logic [BMU_XLEN-1:0] in2_i,
  output logic [BMU_XLEN-1:0] sh1add_o,
  output logic [BMU_XLEN-1:0] sh2add_o,
  output logic [BMU_XLEN-1:0] sh3add_o,
  output logic [BMU_XLEN-1:0] andn_o,
  output logic [BMU_XLEN-1:0] orn_o,
  output logic [BMU_XLEN-1:0] xnor_o,
  output logic [BMU_XLEN-1:0] clz_o,
  output logic [BMU_XLEN-1:0] ctz_o,
  output logic [BMU_XLEN-1:0] cpop_o,
  output logic [BMU_XLEN-1:0] min_o,
  output logic [BMU_XLEN-1:0] max_o,
  output logic [BMU_XLEN-1:0] minu_o,
  output logic [BMU_XLEN-1:0] maxu_o,
  output logic [BMU_XLEN-1:0] sextb_o,
  output logic [BMU_XLEN-1:0] sexth_o,
  output logic [BMU_XLEN-1:0] zexth_o,
  output logic [BMU_XLEN-1:0] rol_o,
  output logic [BMU_XLEN-1:0] ror_o,
  output logic [BMU_XLEN-1:0] orcb_o,
  output logic [BMU_XLEN-1:0] rev8_o
);

  logic [4:0] shamt;
  logic [5:0] shamt_inv;
  logic [5:0] clz_cnt;
  logic [5:0] ctz_cnt;
  logic [5:0] cpop_cnt;

  assign sh1add_o = (in1_i << 1) + in2_i;
  assign sh2add_o = (in1_i << 2) + in2_i;
  assign sh3add_o = (in1_i << 3) + in2_i;

  assign andn_o = in1_i & ~in2_i;
  assign orn_o  = in1_i | ~in2_i;
  assign xnor_o = ~(in1_i ^ in2_i);

  // Highest set bit wins for CLZ, lowest for CTZ; an all-zero input leaves
  // the default of 32.
  always_comb begin
    clz_cnt = 6'd32;
    for (int i = 0; i < BMU_XLEN; i++) begin
      if (in1_i[i]) clz_cnt = 6'(BMU_XLEN - 1 - i);
    end
  end

  always_comb begin
    ctz_cnt = 6'd32;
    for (int i = BMU_XLEN - 1; i >= 0; i--) begin
      if (in1_i[i]) ctz_cnt = 6'(i);
    end
  end

  always_comb begin
    cpop_cnt = 6'd0;
    for (int i = 0; i < BMU_XLEN; i++) begin
      cpop_cnt = cpop_cnt + {5'd0, in1_i[i]};
    end
  end

  assign clz_o  = {{(BMU_XLEN-6){1'b0}}, clz_cnt};
  assign ctz_o  = {{(BMU_XLEN-6){1'b0}}, ctz_cnt};
  assign cpop_o = {{(BMU_XLEN-6){1'b0}}, cpop_cnt};

  assign min_o  = ($signed(in1_i) < $signed(in2_i)) ? in1_i : in2_i;
  assign max_o  = ($signed(in1_i) < $signed(in2_i)) ? in2_i : in1_i;
  assign minu_o = (in1_i < in2_i) ? in1_i : in2_i;
  assign maxu_o = (in1_i < in2_i) ? in2_i : in1_i;

  assign sextb_o = {{(BMU_XLEN-8){in1_i[7]}}, in1_i[7:0]};
  assign sexth_o = {{(BMU_XLEN-16){in1_i[15]}}, in1_i[15:0]};
  assign zexth_o = {{(BMU_XLEN-16){1'b0}}, in1_i[15:0]};

  // A complementary shift of 32 yields 0, so an amount of 0 returns in1
  // unchanged without a special case.
  assign shamt     = in2_i[4:0];
  assign shamt_inv = 6'd32 - {1'b0, shamt};
  assign rol_o     = (in1_i << shamt) | (in1_i >> shamt_inv);
  assign ror_o     = (in1_i >> shamt) | (in1_i << shamt_inv);

  for (genvar b = 0; b < BMU_XLEN / 8; b++) begin : g_orcb
    assign orcb_o[8*b +: 8] = {8{|in1_i[8*b +: 8]}};
  end

  assign rev8_o = {in1_i[7:0], in1_i[15:8], in1_i[23:16], in1_i[31:24]};

endmodule

`default_nettype wire

// File: rtl/bmu_exec_stage.sv
// ============================================================================
// Module  : bmu_exec_stage
// Purpose : Two-stage pipelined Zba/Zbb execute stage. S1 registers the
//           issued op and operands; zba_zbb computes all results from S1 and
//           the selected one is captured in S2 until writeback takes it.
//           Full valid/ready backpressure, flush, in-order, one op/cycle.
// Ports   : clk_i, rst_i (async, active-high)
//           in_valid_i/in_ready_o, in_op_i, in_rs1_i, in_rs2_i, in_tag_i
//           flush_i
//           out_valid_o/out_ready_i, out_result_o, out_tag_o, out_illegal_o
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bmu_exec_stage
  import bmu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [4:0]          in_op_i,
  input  logic [BMU_XLEN-1:0] in_rs1_i,
  input  logic [BMU_XLEN-1:0] in_rs2_i,
  input  logic [TAG_W-1:0]    in_tag_i,
  input  logic                flush_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [BMU_XLEN-1:0] out_result_o,
  output logic [TAG_W-1:0]    out_tag_o,
  output logic                out_illegal_o
);

  logic                s1_valid;
  bmu_s1_t             s1;
  logic                s2_valid;
  logic [BMU_XLEN-1:0] s2_result;
  logic [TAG_W-1:0]    s2_tag;
  logic                s2_illegal;

  logic                s1_adv;
  logic                s2_adv;
  logic [BMU_XLEN-1:0] result_d;
  logic                illegal_d;

  logic [BMU_XLEN-1:0] sh1add, sh2add, sh3add, andn, orn, xnor_r;
  logic [BMU_XLEN-1:0] clz, ctz, cpop, min_r, max_r, minu, maxu;
  logic [BMU_XLEN-1:0] sextb, sexth, zexth, rol, ror, orcb, rev8;

  // Single ready chain: a stage may load when it is empty or its
  // downstream neighbour is moving this cycle.
  assign s2_adv     = !s2_valid || out_ready_i;
  assign s1_adv     = !s1_valid || s2_adv;
  assign in_ready_o = s1_adv && !rst_i;

  zba_zbb u_zba_zbb (
    .in1_i    (s1.rs1),
    .in2_i    (s1.rs2),
    .sh1add_o (sh1add),
    .sh2add_o (sh2add),
    .sh3add_o (sh3add),
    .andn_o   (andn),
    .orn_o    (orn),
    .xnor_o   (xnor_r),
    .clz_o    (clz),
    .ctz_o    (ctz),
    .cpop_o   (cpop),
    .min_o    (min_r),
    .max_o    (max_r),
    .minu_o   (minu),
    .maxu_o   (maxu),
    .sextb_o  (sextb),
    .sexth_o  (sexth),
    .zexth_o  (zexth),
    .rol_o    (rol),
    .ror_o    (ror),
    .orcb_o   (orcb),
    .rev8_o   (rev8)
  );

  always_comb begin
    result_d  = '0;
    illegal_d = 1'b0;
    case (s1.op)
      BMU_SH1ADD: result_d = sh1add;
      BMU_SH2ADD: result_d = sh2add;
      BMU_SH3ADD: result_d = sh3add;
      BMU_ANDN:   result_d = andn;
      BMU_ORN:    result_d = orn;
      BMU_XNOR:   result_d = xnor_r;
      BMU_CLZ:    result_d = clz;
      BMU_CTZ:    result_d = ctz;
      BMU_CPOP:   result_d = cpop;
      BMU_MIN:    result_d = min_r;
      BMU_MAX:    result_d = max_r;
      BMU_MINU:   result_d = minu;
      BMU_MAXU:   result_d = maxu;
      BMU_SEXTB:  result_d = sextb;
      BMU_SEXTH:  result_d = sexth;
      BMU_ZEXTH:  result_d = zexth;
      BMU_ROL:    result_d = rol;
      BMU_ROR:    result_d = ror;
      BMU_ORCB:   result_d = orcb;
      BMU_REV8:   result_d = rev8;
      default:    illegal_d = 1'b1;
    endcase
  end

  // Payload registers load only when their stage advances; flush and
  // consume touch the valid bits alone.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid   <= 1'b0;
      s1         <= '0;
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_tag     <= '0;
      s2_illegal <= 1'b0;
    end else begin
      if (flush_i) begin
        s1_valid <= 1'b0;
      end else if (s1_adv) begin
        s1_valid <= in_valid_i;
      end

      if (in_valid_i && in_ready_o) begin
        s1.op  <= in_op_i;
        s1.rs1 <= in_rs1_i;
        s1.rs2 <= in_rs2_i;
        s1.tag <= BMU_TAG_MAX_W'(in_tag_i);
      end

      if (flush_i) begin
        s2_valid <= 1'b0;
      end else if (s2_adv) begin
        s2_valid <= s1_valid;
      end

      if (s1_valid && s2_adv) begin
        s2_result  <= result_d;
        s2_tag     <= s1.tag[TAG_W-1:0];
        s2_illegal <= illegal_d;
      end
    end
  end

  // The record's tag field is wider than TAG_W; the padding is never read.
  if (TAG_W < BMU_TAG_MAX_W) begin : g_tag_pad
    logic tag_pad_unused;
    assign tag_pad_unused = ^s1.tag[BMU_TAG_MAX_W-1:TAG_W];
  end

  assign out_valid_o   = s2_valid;
  assign out_result_o  = s2_result;
  assign out_tag_o     = s2_tag;
  assign out_illegal_o = s2_illegal;

endmodule

`default_nettype wire

// File: tb/tb_bmu_exec_stage.sv
// ============================================================================
// Module  : tb_bmu_exec_stage
// Purpose : Directed self-checking bench for bmu_exec_stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bmu_exec_stage;

  localparam int TAG_W = 5;

  localparam logic [4:0] OP_SH1ADD = 5'd0,  OP_SH2ADD = 5'd1,  OP_SH3ADD = 5'd2;
  localparam logic [4:0] OP_ANDN   = 5'd3,  OP_ORN    = 5'd4,  OP_XNOR   = 5'd5;
  localparam logic [4:0] OP_CLZ    = 5'd6,  OP_CTZ    = 5'd7,  OP_CPOP   = 5'd8;
  localparam logic [4:0] OP_MIN    = 5'd9,  OP_MAX    = 5'd10, OP_MINU   = 5'd11;
  localparam logic [4:0] OP_MAXU   = 5'd12, OP_SEXTB  = 5'd13, OP_SEXTH  = 5'd14;
  localparam logic [4:0] OP_ZEXTH  = 5'd15, OP_ROL    = 5'd16, OP_ROR    = 5'd17;
  localparam logic [4:0] OP_ORCB   = 5'd18, OP_REV8   = 5'd19;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_op;
  logic [31:0]      in_rs1;
  logic [31:0]      in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  int checks;
  int fails;

  bmu_exec_stage #(.TAG_W(TAG_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_op_i       (in_op),
    .in_rs1_i      (in_rs1),
    .in_rs2_i      (in_rs2),
    .in_tag_i      (in_tag),
    .flush_i       (flush),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_result_o  (out_result),
    .out_tag_o     (out_tag),
    .out_illegal_o (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_result !== 32'd0) begin fails++; $display("FAIL reset_result: got %h expected 0", out_result); end
    checks++; if (out_tag !== 5'd0) begin fails++; $display("FAIL reset_tag: got %h expected 0", out_tag); end
    checks++; if (out_illegal !== 1'b0) begin fails++; $display("FAIL reset_illegal: got %b expected 0", out_illegal); end
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_release_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_sh2add();
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = OP_SH2ADD; in_rs1 = 32'd3; in_rs2 = 32'd10; in_tag = 5'd7;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL sh2add_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sh2add_early_valid: got %b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL sh2add_valid: got %b expected 1", out_valid); end
    checks++; if (out_result !== 32'd22) begin fails++; $display("FAIL sh2add_result: got %h expected %h", out_result, 32'd22); end
    checks++; if (out_tag !== 5'd7) begin fails++; $display("FAIL sh2add_tag: got %h expected %h", out_tag, 5'd7); end
    checks++; if (out_illegal !== 1'b0) begin fails++; $display("FAIL sh2add_illegal: got %b expected 0", out_illegal); end
    tick();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sh2add_consumed: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  ops [20];
    logic [31:0] a   [20];
    logic [31:0] b   [20];
    logic [31:0] exp_r [20];
    ops   = '{OP_CLZ, OP_CTZ, OP_CPOP, OP_REV8, OP_SH1ADD, OP_SH3ADD, OP_ANDN, OP_ORN,
              OP_XNOR, OP_MIN, OP_MAX, OP_MINU, OP_MAXU, OP_SEXTB, OP_SEXTH, OP_ZEXTH,
              OP_ORCB, OP_CTZ, OP_CLZ, OP_CPOP};
    a     = '{32'h00010000, 32'h00000000, 32'hF0F0F0F1, 32'h11223344, 32'd5, 32'd2,
              32'hFF00FF00, 32'h00000000, 32'hAAAA0000, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000080, 32'h00018000, 32'hABCD1234,
              32'h00100001, 32'h00000100, 32'h00000000, 32'hFFFFFFFF};
    b     = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd100, 32'd1, 32'h0F0F0F0F, 32'hFFFF0000,
              32'h0000FFFF, 32'd1, 32'd1, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0,
              32'd0, 32'd0, 32'd0, 32'd0};
    exp_r = '{32'd15, 32'd32, 32'd17, 32'h44332211, 32'd110, 32'd17, 32'hF000F000,
              32'h0000FFFF, 32'h55550000, 32'hFFFFFFFF, 32'd1, 32'd1, 32'hFFFFFFFF,
              32'hFFFFFF80, 32'hFFFF8000, 32'h00001234, 32'h00FF00FF, 32'd8, 32'd32,
              32'd32};
    out_ready = 1'b1;
    for (int c = 0; c <= 21; c++) begin
      if (c < 20) begin
        in_valid = 1'b1; in_op = ops[c]; in_rs1 = a[c]; in_rs2 = b[c]; in_tag = 5'(c);
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready[%0d]: got %b expected 1", c, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c == 0) begin
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_first_valid: got %b expected 0", out_valid); end
      end else if (c <= 20) begin
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid[%0d]: got %b expected 1", c-1, out_valid); end
        checks++; if (out_result !== exp_r[c-1]) begin fails++; $display("FAIL b2b_result[%0d]: got %h expected %h", c-1, out_result, exp_r[c-1]); end
        checks++; if (out_tag !== 5'(c-1)) begin fails++; $display("FAIL b2b_tag[%0d]: got %0d expected %0d", c-1, out_tag, c-1); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain_valid: got %b expected 0", out_valid); end
      end
    end
  endtask

  task automatic test_rotates();
    logic [4:0]  ops [5];
    logic [31:0] b   [5];
    logic [31:0] exp_r [5];
    ops   = '{OP_ROR, OP_ROR, OP_ROL, OP_ROL, OP_ROR};
    b     = '{32'd0, 32'd33, 32'd4, 32'd0, 32'd4};
    exp_r = '{32'h80000001, 32'hC0000000, 32'h00000018, 32'h80000001, 32'h18000000};
    out_ready = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      if (c < 5) begin
        in_valid = 1'b1; in_op = ops[c]; in_rs1 = 32'h80000001; in_rs2 = b[c]; in_tag = 5'(c + 20);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c >= 1) begin
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rot_valid[%0d]: got %b expected 1", c-1, out_valid); end
        checks++; if (out_result !== exp_r[c-1]) begin fails++; $display("FAIL rot_result[%0d]: got %h expected %h", c-1, out_result, exp_r[c-1]); end
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_r [4];
    logic [31:0] got_r [4];
    logic [4:0]  got_t [4];
    int acc;
    int del;
    exp_r = '{32'd4, 32'd9, 32'd14, 32'd19};
    acc = 0; del = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 30 && del < 4; c++) begin
      if (c == 5) out_ready = 1'b1;
      in_valid = (acc < 4); in_op = OP_SH2ADD;
      in_rs1 = 32'(acc + 1); in_rs2 = 32'(acc); in_tag = 5'(10 + acc);
      #1;
      if (c < 2) begin
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_high[%0d]: got %b expected 1", c, in_ready); end
      end else if (c < 5) begin
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_low[%0d]: got %b expected 0", c, in_ready); end
        checks++; if (out_valid !== 1'b1 || out_result !== 32'd4 || out_tag !== 5'd10) begin
          fails++; $display("FAIL bp_hold[%0d]: got v=%b r=%h t=%0d expected v=1 r=4 t=10", c, out_valid, out_result, out_tag);
        end
      end
      if (out_valid && out_ready) begin
        got_r[del] = out_result; got_t[del] = out_tag; del++;
      end
      if (in_valid && in_ready) acc++;
      if (c == 4) begin
        checks++; if (acc != 2) begin fails++; $display("FAIL bp_accepted: got %0d expected 2", acc); end
      end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (del != 4) begin fails++; $display("FAIL bp_delivered: got %0d expected 4", del); end
    for (int k = 0; k < del; k++) begin
      checks++; if (got_r[k] !== exp_r[k] || got_t[k] !== 5'(10 + k)) begin
        fails++; $display("FAIL bp_order[%0d]: got r=%h t=%0d expected r=%h t=%0d", k, got_r[k], got_t[k], exp_r[k], 10 + k);
      end
    end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_no_dup: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; flush = 1'b0;
    in_valid = 1'b1; in_op = OP_SH1ADD; in_rs1 = 32'd1; in_rs2 = 32'd1; in_tag = 5'd1;
    tick();
    in_tag = 5'd2;
    tick();
    in_tag = 5'd3; flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_full_ready: got %b expected 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_ghost[%0d]: got %b expected 0", c, out_valid); end
    end
    // Beat offered while flushing with the stage ready: consumed, then dropped.
    in_valid = 1'b1; in_tag = 5'd4; flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_empty_ready: got %b expected 1", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_drop[%0d]: got %b expected 0", c, out_valid); end
    end
    in_valid = 1'b1; in_op = OP_XNOR; in_rs1 = 32'h0F0F0F0F; in_rs2 = 32'h00FF00FF; in_tag = 5'd9;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_result !== 32'hF00FF00F || out_tag !== 5'd9) begin
      fails++; $display("FAIL flush_after: got v=%b r=%h t=%0d expected v=1 r=f00ff00f t=9", out_valid, out_result, out_tag);
    end
    tick();
  endtask

  task automatic test_illegal();
    logic [4:0]  ops [3];
    logic [31:0] exp_r [3];
    logic        exp_i [3];
    ops = '{5'd25, 5'd20, OP_REV8};
    exp_r = '{32'd0, 32'd0, 32'hFFFFFFFF};
    exp_i = '{1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      if (c < 3) begin
        in_valid = 1'b1; in_op = ops[c]; in_rs1 = 32'hFFFFFFFF; in_rs2 = 32'hFFFFFFFF; in_tag = 5'(c + 4);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c >= 1) begin
        checks++; if (out_valid !== 1'b1 || out_result !== exp_r[c-1] || out_illegal !== exp_i[c-1] || out_tag !== 5'(c + 3)) begin
          fails++; $display("FAIL illegal[%0d]: got v=%b r=%h ill=%b t=%0d expected v=1 r=%h ill=%b t=%0d",
                            c-1, out_valid, out_result, out_illegal, out_tag, exp_r[c-1], exp_i[c-1], c + 3);
        end
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = OP_ANDN; in_rs1 = 32'hFFFFFFFF; in_rs2 = 32'h0; in_tag = 5'd17;
    tick();
    tick();
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rstmid_prefill: got %b expected 1", out_valid); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rstmid_ready: got %b expected 0", in_ready); end
    checks++; if (out_result !== 32'd0 || out_tag !== 5'd0) begin
      fails++; $display("FAIL rstmid_payload: got r=%h t=%0d expected r=0 t=0", out_result, out_tag);
    end
    tick();
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rstmid_ready_held: got %b expected 0", in_ready); end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_release_ready: got %b expected 1", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_empty[%0d]: got %b expected 0", c, out_valid); end
    end
  endtask

  initial begin
    checks = 0; fails = 0;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;
    flush = 1'b0; out_ready = 1'b0;
    test_reset();
    test_sh2add();
    test_back_to_back();
    test_rotates();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/bmu_exec_stage.md
# bmu_exec_stage

Two-stage pipelined bit-manipulation execute stage for Zba/Zbb instructions. It sits between the decode/issue stage and the writeback arbiter:
- accepts a decoded bitmanip op and two operands over a valid/ready handshake;
- registers the operands;
- computes all results with the existing combinational `zba_zbb` unit;
- selects the one for the op and holds it in an output register until writeback accepts it.

It provides full backpressure, a flush, and in-order delivery at one op per cycle.

## Interface
Parameters:
- TAG_W, 5, width of the destination-register tag carried alongside each op.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- in_valid_i  in  1  issue offers an op this cycle.
- in_ready_o  out  1  stage accepts the offered op this cycle.
- in_op_i  in  5  op code, `bmu_op_e` from `bmu_pkg`.
- in_rs1_i  in  32  operand 1 (maps to `in1_i` of `zba_zbb`).
- in_rs2_i  in  32  operand 2 (maps to `in2_i` of `zba_zbb`).
- in_tag_i  in  TAG_W  destination tag.
- flush_i  in  1  kill all in-flight ops.
- out_valid_o  out  1  result available.
- out_ready_i  in  1  writeback consumes the result.
- out_result_o  out  32  selected result.
- out_tag_o  out  TAG_W  tag of the result.
- out_illegal_o  out  1  op code was outside `bmu_op_e`; the result is 0.

## Operation
- **S1 register** holds {valid, op, rs1, rs2, tag}. **S2 register** holds {valid, result, tag, illegal}.
- **Advance conditions:**
  - s2_adv = !s2_valid || out_ready_i.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready_o = s1_adv && !rst_i.
- **Accept:** in_valid_i && in_ready_o loads S1.
- **S1 to S2:** when s1_valid && s2_adv, S2 loads the mux of `zba_zbb` outputs selected by the S1 op.
  - An undefined op code gives result 0 and illegal=1.
- **Transfer:** when s2_valid && out_ready_i, the result is consumed. S2 reloads or clears in the same cycle.
- **Op set (20 ops):** SH1ADD, SH2ADD, SH3ADD, ANDN, ORN, XNOR, CLZ, CTZ, CPOP, MIN, MAX, MINU, MAXU, SEXTB, SEXTH, ZEXTH, ROL, ROR, ORCB, REV8.
- **Widths and semantics:**
  - All results are 32-bit.
  - Rotate amount is rs2[4:0]. An amount of 0 returns rs1 unchanged.
  - CLZ/CTZ of 0 return 32. CPOP range is 0..32.
- **Flush:** flush_i clears s1_valid and s2_valid at the next edge.
  - An input beat offered in the flush cycle is dropped. in_ready_o may be high; the beat counts as consumed.
  - A result transferring in the flush cycle (out_valid_o && out_ready_i) still counts as delivered.
- **Payload hold:** payload registers do not clear on flush or consume. Only the valid bits gate them.
- **Reset:** all valids are 0; out_result_o, out_tag_o and out_illegal_o are 0; in_ready_o is 0 while rst_i is high and 1 in the first cycle after release. Reset mid-operation discards everything.

## Timing
- **Latency:** accept at edge N gives out_valid_o high after edge N+1, i.e. during cycle N+1..N+2. The minimum is 2 cycles from in_valid_i to consumable result.
- **Throughput:** one op per cycle with out_ready_i held high.
- **Stalls:**
  - With out_ready_i low, at most 2 ops are held (S1 and S2).
  - in_ready_o drops combinationally once both stages are full.
- **Output stability:** out_valid_o/out_result_o/out_tag_o are registered. They are stable while out_valid_o && !out_ready_i.
- **Combinational paths:**
  - in_ready_o depends combinationally on out_ready_i (single ready chain, no skid).
  - No combinational path from in_* to out_*.
- **Ordering:** results leave in acceptance order.

## Structure
- **`bmu_pkg`:** `bmu_op_e` (5-bit enum, values 0..19, values 20..31 illegal), the `BMU_XLEN=32` constant, and a packed `bmu_s1_t` struct {op, rs1, rs2, tag}.
- **Sub-modules:** instantiate the existing `zba_zbb` between S1 and S2, driven from S1 registers. The result mux stays in this module. No other sub-modules.

## Test plan
- **SH2ADD:** rs1=3, rs2=10, out_ready_i=1 → out_result_o=22 exactly 2 cycles after accept; tag echoed.
- **Back-to-back stream:** CLZ 0x00010000, CTZ 0x00000000, CPOP 0xF0F0F0F1, REV8 0x11223344 → results 15, 32, 17, 0x44332211 on 4 consecutive cycles, in order.
- **Rotates:** ROR 0x80000001 by rs2=0 → 0x80000001; ROR by rs2=33 → 0xC0000000; ROL 0x80000001 by 4 → 0x00000018.
- **Backpressure:** out_ready_i low for 5 cycles while 4 ops are offered → exactly 2 accepted, in_ready_o low from the 3rd offer. After out_ready_i rises, all 4 ops deliver in order with no loss or duplication.
- **Flush:** flush_i with both stages full and an input offered → next cycle out_valid_o=0, nothing from those 3 ops ever appears; the following op completes normally.
- **Illegal op and reset:** op=25 with rs1=0xFFFFFFFF → result 0, out_illegal_o=1. Asserting rst_i asynchronously mid-stream → out_valid_o=0 immediately and in_ready_o=0 during reset; after release in_ready_o=1 and S1/S2 are empty.
